// File: rtl/cadence_meter.sv
// Crank cadence meter: sensor sync, debounce, edge-to-edge period, 2^AVG_LOG2 averaging and a
// restoring divider turning the mean period into RPM. Declares a stopped crank on timeout.
module cadence_meter #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned MAGNETS         = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50_000,
    parameter int unsigned TIMEOUT_CYCLES  = 75_000_000,
    parameter int unsigned AVG_LOG2        = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PedalSensor,
    output logic [7:0] Cadence,
    output logic       CadenceValid,
    output logic       PedalStopped
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SUM_W = 32 + AVG_LOG2;
    localparam logic [31:0] K     = 32'(64'(60) * 64'(CLK_HZ) / 64'(MAGNETS));

    typedef enum logic [2:0] {StIdle, StArmed, StMeasure, StDivide, StUpdate} state_t;

    // Front end
    logic        r_sync1, r_sync2;
    logic [31:0] r_db_cnt, w_db_cnt_next, w_db_cnt_inc;
    logic        r_db_level, w_db_level_next;
    logic        r_event, w_event_next;
    logic [31:0] r_period_cnt, w_period_cnt_next;
    logic        w_db_differ, w_timeout;

    // Measurement FSM and datapath
    state_t             r_state, w_state_next;
    logic [31:0]        r_hist [DEPTH];
    logic [31:0]        w_hist_next [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, w_wr_ptr_next;
    logic [SUM_W-1:0]   r_sum, w_sum_next, w_sum_upd;
    logic               r_pend_valid, w_pend_valid_next;
    logic [31:0]        r_pend_period, w_pend_period_next;
    logic [31:0]        w_new_period;
    logic [4:0]         r_div_idx, w_div_idx_next;
    logic [31:0]        r_divisor, w_divisor_next;
    logic [31:0]        r_rem, w_rem_next;
    logic [31:0]        r_quot, w_quot_next;
    logic [32:0]        w_rem_shift, w_rem_diff;
    logic               w_abort;
    logic [7:0]         r_cadence, w_cadence_next;
    logic               r_valid, w_valid_next;
    logic               r_stopped, w_stopped_next;

    always_comb begin
        w_db_cnt_inc    = r_db_cnt + 32'd1;
        w_db_differ     = (r_sync2 != r_db_level);
        w_db_cnt_next   = '0;
        w_db_level_next = r_db_level;
        w_event_next    = 1'b0;
        if (w_db_differ) begin
            if (w_db_cnt_inc >= DEBOUNCE_CYCLES) begin
                w_db_level_next = r_sync2;
                w_event_next    = r_sync2;
            end else begin
                w_db_cnt_next = w_db_cnt_inc;
            end
        end
        if (r_event) begin
            w_period_cnt_next = 32'd1;
        end else if (r_period_cnt < TIMEOUT_CYCLES) begin
            w_period_cnt_next = r_period_cnt + 32'd1;
        end else begin
            w_period_cnt_next = r_period_cnt;
        end
        // An event in the same cycle beats the timeout.
        w_timeout = (r_period_cnt >= TIMEOUT_CYCLES) && !r_event;
    end

    // Restoring divider step; remainder stays below the divisor, so bit 32 of the
    // difference is a clean borrow flag.
    always_comb begin
        w_rem_shift = {r_rem, r_quot[31]};
        w_rem_diff  = w_rem_shift - {1'b0, r_divisor};
    end

    always_comb begin
        w_state_next       = r_state;
        w_hist_next        = r_hist;
        w_wr_ptr_next      = r_wr_ptr;
        w_sum_next         = r_sum;
        w_pend_valid_next  = r_pend_valid;
        w_pend_period_next = r_pend_period;
        w_div_idx_next     = r_div_idx;
        w_divisor_next     = r_divisor;
        w_rem_next         = r_rem;
        w_quot_next        = r_quot;
        w_cadence_next     = r_cadence;
        w_valid_next       = 1'b0;
        w_stopped_next     = r_stopped;
        w_abort            = 1'b0;
        w_new_period       = r_pend_valid ? r_pend_period : r_period_cnt;
        w_sum_upd          = r_sum - SUM_W'(r_hist[r_wr_ptr]) + SUM_W'(w_new_period);

        unique case (r_state)
            StIdle: begin
                if (r_event) begin
                    w_state_next = StArmed;
                end
            end
            StArmed: begin
                if (r_event) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        w_hist_next[i] = r_period_cnt;
                    end
                    w_wr_ptr_next  = '0;
                    w_sum_next     = SUM_W'(r_period_cnt) << AVG_LOG2;
                    w_divisor_next = r_period_cnt;
                    w_rem_next     = '0;
                    w_quot_next    = K;
                    w_div_idx_next = '0;
                    w_state_next   = StDivide;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            StMeasure: begin
                if (r_pend_valid || r_event) begin
                    w_hist_next[r_wr_ptr] = w_new_period;
                    w_wr_ptr_next = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
                    w_sum_next    = w_sum_upd;
                    // A fresh event arriving while the pending one is applied becomes pending.
                    w_pend_valid_next  = r_pend_valid && r_event;
                    w_pend_period_next = r_period_cnt;
                    w_divisor_next     = w_sum_upd[SUM_W-1:AVG_LOG2];
                    w_rem_next         = '0;
                    w_quot_next        = K;
                    w_div_idx_next     = '0;
                    w_state_next       = StDivide;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            StDivide: begin
                w_rem_next     = w_rem_diff[32] ? w_rem_shift[31:0] : w_rem_diff[31:0];
                w_quot_next    = {r_quot[30:0], ~w_rem_diff[32]};
                w_div_idx_next = r_div_idx + 5'd1;
                if (r_div_idx == 5'd31) begin
                    w_state_next = StUpdate;
                end
                if (r_event) begin
                    w_pend_valid_next  = 1'b1;
                    w_pend_period_next = r_period_cnt;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            StUpdate: begin
                w_cadence_next = (r_quot > 32'd255) ? 8'hFF : r_quot[7:0];
                w_valid_next   = 1'b1;
                w_stopped_next = 1'b0;
                w_state_next   = StMeasure;
                if (r_event) begin
                    w_pend_valid_next  = 1'b1;
                    w_pend_period_next = r_period_cnt;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        if (w_abort) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                w_hist_next[i] = '0;
            end
            w_wr_ptr_next     = '0;
            w_sum_next        = '0;
            w_pend_valid_next = 1'b0;
            w_cadence_next    = 8'd0;
            w_stopped_next    = 1'b1;
            w_valid_next      = (r_state != StArmed);
            w_state_next      = StIdle;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_db_cnt      <= '0;
            r_db_level    <= 1'b0;
            r_event       <= 1'b0;
            r_period_cnt  <= '0;
            r_state       <= StIdle;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
            r_wr_ptr      <= '0;
            r_sum         <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_period <= '0;
            r_div_idx     <= '0;
            r_divisor     <= '0;
            r_rem         <= '0;
            r_quot        <= '0;
            r_cadence     <= 8'd0;
            r_valid       <= 1'b0;
            r_stopped     <= 1'b1;
        end else begin
            r_sync1       <= PedalSensor;
            r_sync2       <= r_sync1;
            r_db_cnt      <= w_db_cnt_next;
            r_db_level    <= w_db_level_next;
            r_event       <= w_event_next;
            r_period_cnt  <= w_period_cnt_next;
            r_state       <= w_state_next;
            r_hist        <= w_hist_next;
            r_wr_ptr      <= w_wr_ptr_next;
            r_sum         <= w_sum_next;
            r_pend_valid  <= w_pend_valid_next;
            r_pend_period <= w_pend_period_next;
            r_div_idx     <= w_div_idx_next;
            r_divisor     <= w_divisor_next;
            r_rem         <= w_rem_next;
            r_quot        <= w_quot_next;
            r_cadence     <= w_cadence_next;
            r_valid       <= w_valid_next;
            r_stopped     <= w_stopped_next;
        end
    end

    assign Cadence      = r_cadence;
    assign CadenceValid = r_valid;
    assign PedalStopped = r_stopped;

endmodule

// File: tb/tb_cadence_meter.sv
// Directed bench for cadence_meter: steady, averaging, glitch, saturation, timeout and reset.
module tb_cadence_meter;

    // Clock and periods are 100x smaller than the nominal plan; K/period ratios, and so every
    // expected RPM, are unchanged (K = 60*10_000/8 = 75_000).
    localparam int unsigned CLK_HZ          = 10_000;
    localparam int unsigned MAGNETS         = 8;
    localparam int unsigned DEBOUNCE_CYCLES = 10;
    localparam int unsigned TIMEOUT_CYCLES  = 2_000;
    localparam int unsigned AVG_LOG2        = 2;

    // Raw rise to CadenceValid: 2 sync flops, DEBOUNCE_CYCLES to flip the level, then 34.
    localparam int RISE_TO_VALID = 2 + DEBOUNCE_CYCLES + 34;
    // Raw rise to timeout pulse: event cycle at +12, counter hits TIMEOUT, registered output +1.
    localparam int RISE_TO_TIMEOUT = 2 + DEBOUNCE_CYCLES + TIMEOUT_CYCLES + 1;

    logic       CLOCK_50;
    logic       reset;
    logic       PedalSensor;
    logic [7:0] Cadence;
    logic       CadenceValid;
    logic       PedalStopped;

    int cyc;
    int n_valid;
    int last_cad;
    int last_cyc;
    int last_rise;
    int n_checks;
    int n_fail;

    cadence_meter #(
        .CLK_HZ         (CLK_HZ),
        .MAGNETS        (MAGNETS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .AVG_LOG2       (AVG_LOG2)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .PedalSensor (PedalSensor),
        .Cadence     (Cadence),
        .CadenceValid(CadenceValid),
        .PedalStopped(PedalStopped)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    initial begin
        n_valid  = 0;
        last_cad = -1;
        last_cyc = -1;
    end
    always @(negedge CLOCK_50) begin
        if (CadenceValid) begin
            n_valid  <= n_valid + 1;
            last_cad <= int'(Cadence);
            last_cyc <= cyc;
        end
    end

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // First rise from a stopped crank: no output may follow.
    task automatic start_edge(input string tag);
        int n0;
        PedalSensor = 1'b1;
        last_rise   = cyc;
        n0          = n_valid;
        wait_until(last_rise + 60);
        check_eq({tag, "_nvalid"}, n_valid - n0, 0);
        check_eq({tag, "_stopped"}, int'(PedalStopped), 1);
    endtask

    // Next rise `len` cycles after the previous one, optionally with a short glitch in the low half.
    task automatic step(input string tag, input int len, input bit glitch, input int exp_n,
                        input int exp_cad);
        int n0;
        wait_until(last_rise + len / 2);
        PedalSensor = 1'b0;
        if (glitch) begin
            wait_until(last_rise + len / 2 + 100);
            PedalSensor = 1'b1;
            wait_until(last_rise + len / 2 + 105);
            PedalSensor = 1'b0;
        end
        wait_until(last_rise + len);
        PedalSensor = 1'b1;
        last_rise   = cyc;
        n0          = n_valid;
        wait_until(last_rise + 60);
        check_eq({tag, "_nvalid"}, n_valid - n0, exp_n);
        if (exp_n == 1) begin
            check_eq({tag, "_cadence"}, last_cad, exp_cad);
            check_eq({tag, "_latency"}, last_cyc - last_rise, RISE_TO_VALID);
        end
    endtask

    initial begin
        int n0;
        n_checks    = 0;
        n_fail      = 0;
        last_rise   = 0;
        reset       = 1'b1;
        PedalSensor = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_eq("reset_cadence", int'(Cadence), 0);
        check_eq("reset_valid", int'(CadenceValid), 0);
        check_eq("reset_stopped", int'(PedalStopped), 1);
        reset = 1'b0;
        repeat (20) @(posedge CLOCK_50);
        #1;

        // Steady 60 RPM
        start_edge("steady_first");
        step("steady_second", 1250, 1'b0, 1, 60);
        check_eq("steady_stopped_low", int'(PedalStopped), 0);
        step("steady_3", 1250, 1'b0, 1, 60);
        step("steady_4", 1250, 1'b0, 1, 60);

        // Glitches between real edges
        step("glitch_1", 1250, 1'b1, 1, 60);
        step("glitch_2", 1250, 1'b1, 1, 60);

        // Averaging: sums 4750, 4500, 4750, 5000 over four slots
        step("avg_1000_a", 1000, 1'b0, 1, 63);
        step("avg_1000_b", 1000, 1'b0, 1, 66);
        step("avg_1500_a", 1500, 1'b0, 1, 63);
        step("avg_1500_b", 1500, 1'b0, 1, 60);

        // Timeout after the last edge
        wait_until(last_rise + 625);
        PedalSensor = 1'b0;
        n0 = n_valid;
        wait_until(last_rise + RISE_TO_TIMEOUT + 50);
        check_eq("timeout_nvalid", n_valid - n0, 1);
        check_eq("timeout_pulse_cadence", last_cad, 0);
        check_eq("timeout_latency", last_cyc - last_rise, RISE_TO_TIMEOUT);
        check_eq("timeout_cadence", int'(Cadence), 0);
        check_eq("timeout_stopped", int'(PedalStopped), 1);
        wait_until(last_rise + RISE_TO_TIMEOUT + 600);
        check_eq("idle_no_repeat", n_valid - n0, 1);

        // Resume at 300 RPM: saturates
        start_edge("resume_first");
        step("sat_1", 250, 1'b0, 1, 255);
        step("sat_2", 250, 1'b0, 1, 255);
        step("sat_3", 250, 1'b0, 1, 255);

        // Reset 10 cycles after an event, while dividing
        wait_until(last_rise + 125);
        PedalSensor = 1'b0;
        wait_until(last_rise + 250);
        PedalSensor = 1'b1;
        last_rise   = cyc;
        n0          = n_valid;
        wait_until(last_rise + 2 + DEBOUNCE_CYCLES + 10);
        reset = 1'b1;
        #1;
        check_eq("midreset_cadence", int'(Cadence), 0);
        check_eq("midreset_valid", int'(CadenceValid), 0);
        check_eq("midreset_stopped", int'(PedalStopped), 1);
        repeat (5) @(posedge CLOCK_50);
        PedalSensor = 1'b0;
        repeat (20) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        repeat (100) @(posedge CLOCK_50);
        #1;
        check_eq("postreset_no_valid", n_valid - n0, 0);
        check_eq("postreset_stopped", int'(PedalStopped), 1);

        start_edge("postreset_first");
        step("postreset_100_a", 750, 1'b0, 1, 100);
        step("postreset_100_b", 750, 1'b0, 1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cadence_meter.md
Name: cadence_meter

Overview:
- Measures pedal cadence from the crank hall/reed sensor.
- Delivers an 8-bit RPM value to the assistance algorithm's cadence input.
- Input path: synchroniser, then debounce, then edge-to-edge period counter, then period averaging, then a sequential divider that converts period to RPM.
- Flags a stopped crank after a timeout so assistance drops to zero.

Parameters:
- CLK_HZ, 50_000_000, clock frequency in Hz.
- MAGNETS, 8, sensor pulses per crank revolution.
- DEBOUNCE_CYCLES, 50_000, consecutive stable cycles required before the debounced level changes (1 ms).
- TIMEOUT_CYCLES, 75_000_000, cycles without a debounced rising edge before the crank is declared stopped (1.5 s).
- AVG_LOG2, 2, log2 of the averaging depth (4 periods).

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- PedalSensor  in  1  raw asynchronous sensor level.
- Cadence  out  8  averaged cadence in RPM, saturating at 255.
- CadenceValid  out  1  one-cycle strobe when Cadence updates.
- PedalStopped  out  1  high while no pedalling is detected.

Behaviour:
- Reset values:
  - Cadence=0, CadenceValid=0, PedalStopped=1.
  - Period history, running sum, period counter and debounced level all cleared; FSM in IDLE.
- Synchroniser: 2-flop on PedalSensor. Only the second flop is used downstream.
- Debounce:
  - A counter runs while the synced level differs from the debounced level; it is cleared on any match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synced level.
  - An event is a debounced 0->1 transition, asserted for exactly one cycle.
- Period counter:
  - 32-bit; cleared to 1 on an event, otherwise increments.
  - Saturates at TIMEOUT_CYCLES.
  - Period = counter value sampled on the event cycle, i.e. the cycle distance between events.
- Constant K = 60*CLK_HZ/MAGNETS, computed at elaboration (375_000_000 at defaults; must fit 32 bits).
- FSM states:
  - IDLE: stopped. An event moves to ARMED. No period is recorded and there is no output.
  - ARMED: one edge has been seen. The next event latches the period, fills every history slot with it (sum = period<<AVG_LOG2), and moves to DIVIDE.
  - MEASURE: running. An event latches the period, replaces the oldest history slot, and updates sum = sum - oldest + new in the same cycle, then moves to DIVIDE the next cycle.
  - DIVIDE:
    - Restoring divider, one quotient bit per cycle, 32 cycles.
    - Numerator K; divisor = sum>>AVG_LOG2 (truncating).
    - Quotient truncates toward zero.
  - UPDATE:
    - Cadence = min(quotient, 255); CadenceValid=1 for this cycle; PedalStopped=0.
    - Moves to MEASURE.
- Latency: CadenceValid asserts exactly 34 cycles after the event cycle.
- Event during DIVIDE/UPDATE:
  - The period is captured into a one-deep pending register. The counter restarts as normal.
  - The pending period is applied on the MEASURE cycle after UPDATE.
  - A second pending event overwrites the first. This cannot occur for DEBOUNCE_CYCLES > 34.
- Timeout:
  - When the counter reaches TIMEOUT_CYCLES in ARMED, MEASURE or DIVIDE, any divide in flight is abandoned and pending is cleared.
  - Outputs: Cadence=0, PedalStopped=1, CadenceValid pulses once (ARMED excluded: no pulse, since Cadence is already 0).
  - History is cleared and the FSM goes to IDLE. In IDLE the saturated counter raises no further pulses.
- Timeout vs event in the same cycle: the event wins; timeout is not declared.
- Divisor zero: impossible, since period ≥ DEBOUNCE_CYCLES. If it does occur, Cadence=255.
- Reset asserted mid-operation: all state returns to reset values immediately; no CadenceValid pulse.

Test Plan:
Bench parameters: CLK_HZ=1_000_000, MAGNETS=8 (K=7_500_000), DEBOUNCE_CYCLES=10, TIMEOUT_CYCLES=200_000, AVG_LOG2=2.
1. Steady pedalling: square wave, period 125_000 cycles.
   - No output after the first edge.
   - After the second edge: Cadence=60, CadenceValid exactly 34 cycles after the debounced event, PedalStopped 1->0.
   - Later edges: Cadence stays 60.
2. Averaging: after steady 125_000, periods 100_000, 100_000, 150_000, 150_000.
   - Successive Cadence = 63, 66, 63, 60.
3. Saturation: period 25_000 (300 RPM).
   - Cadence=255 every update.
4. Glitch rejection: 5-cycle high pulses between real edges at 125_000.
   - No extra events; Cadence remains 60.
5. Timeout: stop toggling after steady 60 RPM.
   - 200_000 cycles after the last event: Cadence=0, PedalStopped=1, one CadenceValid.
   - Resuming: first edge gives no output; second edge gives a correct Cadence.
6. Reset mid-DIVIDE: assert reset 10 cycles after an event.
   - Outputs return immediately to 0/0/1; no CadenceValid follows.
   - After release: two edges at 75_000 give Cadence=100.
